// File: rtl/mem_responder_pkg.sv
// Shared datatypes for the memory responder: FSM state encoding, word size,
// and the address legality rule used by both core requests and preloads.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESP    = 2'd3
  } mem_state_t;

  localparam int MEM_WORD_BYTES = 4;

  // A byte address is usable only if it is word aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_words);
    logic [63:0] limit;
    limit = 64'(depth_words) * 64'(MEM_WORD_BYTES);
    return (addr[1:0] == 2'b00) && ({32'd0, addr} < limit);
  endfunction

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Word-wide memory array with one write port and one asynchronous read port.
// Contents are deliberately not reset.
module sp_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts single-cycle read/write strobes from a core,
// samples address/data one cycle later, waits WAIT_CYCLES and answers with a one-cycle mem_resp.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        busy,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ack,
  output mem_state_t  state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_t    state_d;
  logic [3:0]    cnt;
  logic          is_write;
  logic          both;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   wdata_q;

  logic          strobe;
  logic          cap_err;
  logic          to_resp;
  logic          rd_ok;
  logic          commit;
  logic          preload;
  logic [AW-1:0] rd_idx;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign strobe  = mem_read | mem_write;
  assign cap_err = both | ~addr_ok(mem_addr, DEPTH_WORDS);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (strobe) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:    if (cnt == 4'd1) state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the read happens straight out of CAPTURE, so the
  // index and error decision must come from the live address, not the registers.
  assign to_resp = (state_d == ST_RESP) && (state != ST_RESP);
  assign rd_idx  = (state == ST_CAPTURE) ? mem_addr[AW+1:2] : idx;
  assign rd_ok   = ~is_write & ~((state == ST_CAPTURE) ? cap_err : err);

  // Commit only happens in RESP and preload only in IDLE, so the two never collide.
  assign commit    = (state == ST_RESP) && is_write && !err;
  assign preload   = (state == ST_IDLE) && !strobe && ld_en && addr_ok(ld_addr, DEPTH_WORDS);
  assign ram_we    = rst_n & (commit | preload);
  assign ram_waddr = commit ? idx : ld_addr[AW+1:2];
  assign ram_wdata = commit ? wdata_q : ld_data;

  sp_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      mem_rdata <= 32'd0;
      ld_ack    <= 1'b0;
      is_write  <= 1'b0;
      both      <= 1'b0;
      err       <= 1'b0;
      idx       <= '0;
      wdata_q   <= 32'd0;
    end else begin
      state  <= state_d;
      ld_ack <= preload;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            is_write <= mem_write;
            both     <= mem_read & mem_write;
          end
        end
        ST_CAPTURE: begin
          idx     <= mem_addr[AW+1:2];
          wdata_q <= mem_wdata;
          err     <= cap_err;
          cnt     <= 4'(WAIT_CYCLES);
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        default: ;
      endcase
      if (to_resp && rd_ok) mem_rdata <= ram_rdata;
    end
  end

  assign mem_resp = (state == ST_RESP);
  assign mem_err  = mem_resp & err;
  assign busy     = (state != ST_IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 4096, number of 32-bit words in the memory array; a power of two.
REQ-002 Parameter WAIT_CYCLES, 2, wait states between address capture and response; range 0..15.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 mem_read  in  1  single-cycle read strobe from the core.
REQ-006 mem_write  in  1  single-cycle write strobe from the core.
REQ-007 mem_addr  in  32  byte address (core MAR); sampled one cycle after the strobe.
REQ-008 mem_wdata  in  32  write data (core MDR); sampled one cycle after the strobe.
REQ-009 mem_rdata  out  32  read data; held stable from mem_resp until the next accepted request.
REQ-010 mem_resp  out  1  single-cycle completion pulse.
REQ-011 mem_err  out  1  valid only with mem_resp; 1 = access rejected.
REQ-012 busy  out  1  1 whenever state is not IDLE.
REQ-013 ld_en, ld_addr[31:0], ld_data[31:0]  in  bench preload port (word write, byte address).
REQ-014 ld_ack  out  1  pulses one cycle after an honored preload.

Function
REQ-015 FSM states: IDLE, CAPTURE, WAIT, RESP.
REQ-016 IDLE -> CAPTURE when mem_read or mem_write is 1; the request kind is latched at that edge.
REQ-017 CAPTURE samples mem_addr and mem_wdata, loads the wait counter with WAIT_CYCLES, and goes to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-018 WAIT decrements the counter each cycle and goes to RESP when the counter is 1.
REQ-019 RESP drives mem_resp=1 for exactly one cycle, then returns to IDLE.
REQ-020 Latency: a strobe in cycle T gives mem_resp in cycle T+2+WAIT_CYCLES.
REQ-021 Read: mem_rdata takes the array word in the cycle mem_resp rises.
REQ-022 Write: the array word is committed at the end of the RESP cycle, and mem_rdata is unchanged.
REQ-023 Word index = addr[clog2(DEPTH_WORDS)+1:2]; there is no wrap-around.
REQ-024 Error response is a normal RESP with mem_err=1, no array change, and mem_rdata unchanged, when any of these holds:
- addr[1:0] != 0
- addr >= 4*DEPTH_WORDS
- mem_read and mem_write are both 1 at acceptance
REQ-025 Strobes outside IDLE are ignored and are not queued.
REQ-026 A strobe in the RESP cycle is ignored; the next request needs the strobe in IDLE.
REQ-027 Preload is honored only in IDLE with no strobe that cycle; the word is written at that edge.
REQ-028 Preload otherwise: ignored and ld_ack stays 0. An unaligned or out-of-range preload is ignored.
REQ-029 mem_err=0 whenever mem_resp=0.

Reset
REQ-030 With rst_n=0 at an edge: state=IDLE, counter=0, mem_resp=0, mem_err=0, busy=0, ld_ack=0, mem_rdata=0.
REQ-031 Array contents are not reset.
REQ-032 Reset mid-operation abandons the request: no write commit and no mem_resp afterward.

Structure
REQ-033 mem_state_t enum and the MEM_WORD_BYTES=4 constant live in the shared datatypes package.
REQ-034 The array is one sub-module, sp_ram, with 1 read and 1 write port.
REQ-035 The write-port mux (core commit vs preload) lives in mem_responder; the two can never collide per REQ-027.

Verification
REQ-036 Preload 0x100 <- 0x00500093; read strobe with addr 0x100, WAIT_CYCLES=2 -> mem_resp 4 cycles later, mem_rdata=0x00500093, mem_err=0.
REQ-037 Write 0xDEADBEEF to 0x204, then read 0x204 -> rdata 0xDEADBEEF; mem_rdata unchanged during the write response.
REQ-038 Read 0x102 and write to 0x4000 (DEPTH 4096) -> each gives mem_resp with mem_err=1; array unchanged; mem_rdata holds its prior value.
REQ-039 mem_read=mem_write=1 -> mem_err=1; a second strobe during WAIT -> ignored, exactly one mem_resp.
REQ-040 rst_n=0 during WAIT of a write to 0x8 holding 0x11 -> no mem_resp; a later read of 0x8 returns 0x11.
REQ-041 WAIT_CYCLES=0 -> resp at T+2; preload during busy -> ld_ack=0 and word unchanged.
